seven_seg_digit_driver: RTL
===========================

Name: seven_seg_digit_driver

Overview:
Cathode-side companion to the four-digit anode scanner. Follows the scanner's active-low one-hot anode rotation and drives the matching hex digit's segment pattern. Holds a double-buffered 16-bit display value that only changes at frame boundaries, so the display never tears. Inserts a blanking interval at every digit change to prevent ghosting, then drives the board's anode and cathode pins.

Parameters:
BLANK_CYCLES, 2, clock cycles with all anodes off after each anode_in change (0 disables blanking).
CNT_W, 4, width of blank counter; must satisfy BLANK_CYCLES < 2**CNT_W.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
anode_in  input  4  active-low one-hot digit select from scanner; bit0=rightmost digit.
value  input  16  hex value to display; value[3:0] goes to digit 0.
load  input  1  single-cycle strobe capturing value into the pending register.
load_ack  output  1  one-cycle pulse when a captured value becomes visible.
anode_out  output  4  active-low anode pins.
seg  output  7  active-low cathodes; seg[0]=a … seg[6]=g.
err  output  1  sticky flag: anode_in was seen non-one-hot.

Behaviour:
- Reset (async assert, sync release) values:
  - anode_out=4'b1111, seg=7'h7F, load_ack=0, err=0.
  - display reg=16'h0000, pending reg=0, pending_valid=0.
  - blank_cnt=0, prev_anode=4'b1111.
- All outputs are registered. Latency from an anode_in change to the anode_out/seg update is 1 cycle.
- Digit change:
  - A change is any cycle where anode_in != prev_anode. prev_anode updates every cycle.
  - On a change, blank_cnt loads BLANK_CYCLES.
  - While blank_cnt != 0: blank_cnt decrements, anode_out=4'b1111, seg=7'h7F.
  - A further change during blanking reloads blank_cnt.
- Normal drive, when blank_cnt==0 and anode_in is one-hot:
  - anode_out=anode_in.
  - seg=decode(display nibble selected by the low bit of anode_in).
- Illegal anode_in (not exactly one zero): anode_out=4'b1111, seg=7'h7F, err<=1. err clears only on reset.
- Load handshake:
  - load=1 copies value to pending and sets pending_valid.
  - A second load before commit overwrites pending; only one load_ack is produced.
- Frame boundary and commit:
  - A frame boundary is a change cycle where anode_in==4'b1110 and prev_anode!=4'b1110 (the scanner order is 0→1→2→3→0).
  - At a boundary with pending_valid set: display<=pending, pending_valid<=0, load_ack=1 on the next cycle.
  - If load is asserted in the boundary cycle itself, value bypasses pending: display<=value, pending_valid<=0, one load_ack.
- Decode (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset mid-frame: pending is lost, no load_ack, outputs go dark immediately.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digits 3, 2, 1 are forced dark (seg=7'h7F, anode still driven) while they and every more-significant digit are 0. Digit 0 always shows, so 16'h0000 displays "0" and 16'h00A0 displays "A0".
- Undefined: all four digits always decode, so 16'h0000 shows "0000".

Decomposition:
- Package seven_seg_pkg holds:
  - the 16-entry SEG_LUT constant;
  - SEG_OFF=7'h7F and ANODE_OFF=4'b1111;
  - the DIGIT0_SEL=4'b1110 frame-boundary constant;
  - a function mapping a one-hot anode to a 2-bit digit index.
- One natural sub-module: seven_seg_decoder, a combinational nibble→seg LUT with a blank input.

Test Plan:
- Reset while driving, then release, with anode_in cycling 1110→1101→1011→0111 and BLANK_CYCLES=2 → after each change, 1 cycle latency then 2 dark cycles, then seg=1000000 on every digit (display 0000).
- load value=16'h12AF mid-frame (digit 2 active) → old digits persist through digit 3; at the next 1110, digit0 shows F=0001110 and load_ack pulses once; then digits 1, 2, 3 show A, 2, 1.
- Two loads (16'h1111 then 16'h2222) before a boundary → exactly one load_ack; 16'h2222 displayed and 16'h1111 never visible.
- load=16'h0003 in the same cycle anode_in becomes 1110 → digit 0 shows 3 (0110000) this frame, one load_ack.
- anode_in=4'b1100 for 1 cycle → anode_out=1111, seg=7F, err=1 and stays 1 after legal scanning resumes; reset clears it.
- With LEADING_ZERO_BLANK_EN defined, value=16'h00A0 → digits 3 and 2 dark, digit 1 A=0001000, digit 0 0=1000000; value=16'h0000 → only digit 0 lit.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment digit driver.
// Segment encoding is active-low, bit order gfedcba.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam logic [3:0] DIGIT0_SEL = 4'b1110;

  // Index 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [1:0] anode_to_idx(input logic [3:0] anode);
    logic [1:0] idx;
    case (anode)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic anode_legal(input logic [3:0] anode);
    return ($countones(~anode) == 1);
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-low segment decoder with a blank override.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_OFF : SEG_LUT[nibble];

endmodule

// File: rtl/seven_seg_digit_driver.sv
// Cathode/anode driver following an external anode scanner, with frame-synchronous
// double-buffered display value and inter-digit blanking. Option: LEADING_ZERO_BLANK_EN.
module seven_seg_digit_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode_in,
  input  logic [15:0] value,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  anode_out,
  output logic [6:0]  seg,
  output logic        err
);

  logic [3:0]       prev_anode_q;
  logic [CNT_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [15:0]      display_q, display_d;
  logic [15:0]      pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  logic [3:0]       anode_out_q, anode_out_d;
  logic [6:0]       seg_q, seg_d;
  logic             load_ack_q, load_ack_d;
  logic             err_q, err_d;

  logic       change, legal, boundary, drive, lz_blank;
  logic [1:0] digit_idx;
  logic [3:0] nibble;
  logic [6:0] dec_seg;

  assign change    = (anode_in != prev_anode_q);
  assign legal     = anode_legal(anode_in);
  assign boundary  = change && (anode_in == DIGIT0_SEL);
  assign digit_idx = anode_to_idx(anode_in);

  always_comb begin
    blank_cnt_d = blank_cnt_q;
    if (change) begin
      blank_cnt_d = CNT_W'(BLANK_CYCLES);
    end else if (blank_cnt_q != '0) begin
      blank_cnt_d = blank_cnt_q - CNT_W'(1);
    end
  end

  // A load landing on the boundary cycle skips the pending buffer entirely.
  always_comb begin
    display_d       = display_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    load_ack_d      = 1'b0;
    if (boundary && load) begin
      display_d       = value;
      pending_valid_d = 1'b0;
      load_ack_d      = 1'b1;
    end else if (boundary && pending_valid_q) begin
      display_d       = pending_q;
      pending_valid_d = 1'b0;
      load_ack_d      = 1'b1;
    end else if (load) begin
      pending_d       = value;
      pending_valid_d = 1'b1;
    end
  end

  assign nibble = display_d[{digit_idx, 2'b00} +: 4];

  always_comb begin
    lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (digit_idx)
      2'd3:    lz_blank = (display_d[15:12] == 4'h0);
      2'd2:    lz_blank = (display_d[15:8] == 8'h00);
      2'd1:    lz_blank = (display_d[15:4] == 12'h000);
      default: lz_blank = 1'b0;
    endcase
`endif
  end

  seven_seg_decoder u_decoder (
    .nibble (nibble),
    .blank  (lz_blank),
    .seg    (dec_seg)
  );

  // Outputs use the next blank count so the first dark cycle follows the change directly.
  assign drive       = legal && (blank_cnt_d == '0);
  assign anode_out_d = drive ? anode_in : ANODE_OFF;
  assign seg_d       = drive ? dec_seg : SEG_OFF;
  assign err_d       = err_q | ~legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_anode_q    <= ANODE_OFF;
      blank_cnt_q     <= '0;
      display_q       <= 16'h0000;
      pending_q       <= 16'h0000;
      pending_valid_q <= 1'b0;
      anode_out_q     <= ANODE_OFF;
      seg_q           <= SEG_OFF;
      load_ack_q      <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      prev_anode_q    <= anode_in;
      blank_cnt_q     <= blank_cnt_d;
      display_q       <= display_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      anode_out_q     <= anode_out_d;
      seg_q           <= seg_d;
      load_ack_q      <= load_ack_d;
      err_q           <= err_d;
    end
  end

  assign anode_out = anode_out_q;
  assign seg       = seg_q;
  assign load_ack  = load_ack_q;
  assign err       = err_q;

endmodule
